// File: rtl/md_unit_pkg.sv
// Shared encodings for the multiply/divide unit: operation select, FSM states
// and the HI/LO result pair.
package md_unit_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    MD_NONE = 3'd0,
    MD_MTHI = 3'd1,
    MD_MTLO = 3'd2,
    MD_MUL  = 3'd3,
    MD_DIV  = 3'd4
  } md_func_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } md_result_t;

  // Magnitude of a value, interpreted as two's complement only when is_signed.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/md_div_core.sv
// Combinational 32-bit divider, signed or unsigned. Signed results truncate
// toward zero; the remainder follows the sign of the dividend.
module md_div_core
  import md_unit_pkg::*;
(
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            is_signed,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            div_zero
);

  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic [XLEN-1:0] mag_q;
  logic [XLEN-1:0] mag_r;

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    quotient  = '0;
    remainder = '0;
    mag_q     = '0;
    mag_r     = '0;
    div_zero  = (divisor == '0);
    mag_a     = abs_val(dividend, is_signed);
    mag_b     = abs_val(divisor, is_signed);

    if (div_zero) begin
      quotient  = '0;
      remainder = '0;
    end else if (is_signed && dividend == 32'h8000_0000 && divisor == 32'hFFFF_FFFF) begin
      // Most-negative / -1 overflows; the wrapped quotient is the dividend itself.
      quotient  = dividend;
      remainder = '0;
    end else begin
      mag_q     = mag_a / mag_b;
      mag_r     = mag_a % mag_b;
      quotient  = (is_signed && (dividend[XLEN-1] ^ divisor[XLEN-1])) ? -mag_q : mag_q;
      remainder = (is_signed && dividend[XLEN-1]) ? -mag_r : mag_r;
    end
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Results are computed at issue, held pending, and committed after a fixed latency.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            md_en,
  input  logic [2:0]      md_func,
  input  logic            md_sign,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  md_result_t       pend;
  logic             pend_dz;
  logic             commit;

  logic             accept;
  logic             is_mthi, is_mtlo, is_mul, is_div;
  logic [63:0]      op_a_ext, op_b_ext, product;
  logic [XLEN-1:0]  div_q, div_r;
  logic             div_zero;

  // Requests are only honoured while idle; anything presented during BUSY is dropped.
  assign accept  = md_en && (state == MD_IDLE);
  assign is_mthi = accept && (md_func == MD_MTHI);
  assign is_mtlo = accept && (md_func == MD_MTLO);
  assign is_mul  = accept && (md_func == MD_MUL);
  assign is_div  = accept && (md_func == MD_DIV);

  assign op_a_ext = md_sign ? {{XLEN{src_a[XLEN-1]}}, src_a} : {{XLEN{1'b0}}, src_a};
  assign op_b_ext = md_sign ? {{XLEN{src_b[XLEN-1]}}, src_b} : {{XLEN{1'b0}}, src_b};
  assign product  = op_a_ext * op_b_ext;

  md_div_core u_div (
    .dividend  (src_a),
    .divisor   (src_b),
    .is_signed (md_sign),
    .quotient  (div_q),
    .remainder (div_r),
    .div_zero  (div_zero)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      MD_IDLE: begin
        if (is_mul) begin
          state_nxt = MD_BUSY;
          cnt_nxt   = MUL_LOAD;
        end else if (is_div) begin
          state_nxt = MD_BUSY;
          cnt_nxt   = DIV_LOAD;
        end
      end
      MD_BUSY: begin
        if (cnt == '0) begin
          state_nxt = MD_IDLE;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = MD_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: the pending result is reset too, so an aborted op leaves nothing stale behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend    <= '0;
      pend_dz <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= commit;
      if (is_mul) begin
        pend    <= product;
        pend_dz <= 1'b0;
      end else if (is_div) begin
        pend.hi <= div_r;
        pend.lo <= div_q;
        pend_dz <= div_zero;
      end

      // Commit only happens in BUSY and moves only happen in IDLE, so they never collide.
      if (commit) begin
        if (!pend_dz) begin
          hi <= pend.hi;
          lo <= pend.lo;
        end
      end else begin
        if (is_mthi) hi <= src_a;
        if (is_mtlo) lo <= src_a;
      end
    end
  end

  assign busy = (state == MD_BUSY);

endmodule
